game_sequencer: RTL
===================

# game_sequencer

Sequences one Prime-Prediction game around the score updater. It starts a timed round for a selected player and asserts `game_timeout` when the round ends. It then latches the final score, updates the per-player personal-best and overall high-score records, and steps the score display through personal best, high score and winner. It sits between the front-panel inputs (start/skip buttons, player switches, 1 Hz tick) and the score updater's `game_timeout`/`tg1`/`tg2`/record inputs.

## Interface
- `NUM_PLAYERS`, 4: number of player slots; 1..7.
- `GAME_TICKS`, 30: round length in `tick` pulses; 1..99.
- `DWELL_TICKS`, 3: display dwell per result screen, in `tick` pulses; ≥1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low.
- `tick` in 1: one-cycle 1 Hz enable.
- `start` in 1: one-cycle pulse, starts a round.
- `skip` in 1: one-cycle pulse, advances the result screen early.
- `player_sel` in 3: 0-based player index, sampled on an accepted `start`.
- `current_score` in 7: running score from the score updater.
- `game_timeout` out 1: 1 whenever not in PLAY.
- `tg1`, `tg2` out 1 each: score-updater display select.
- `highest_score` out 7: overall record.
- `personal_best` out 7: record of the latched player.
- `player_won` out 3: 1-based id of the record holder; 0 means none.
- `ticks_left` out 7: remaining round ticks.
- `busy` out 1: 1 when not in IDLE.

## Operation
- States: IDLE, PLAY, LATCH, SHOW_PB, SHOW_HS, SHOW_WON.
- IDLE:
  - Outputs: `game_timeout`=1, tg=00.
  - `start` → PLAY. Latch `player_sel`; if `player_sel` ≥ `NUM_PLAYERS`, latch 0. Load `ticks_left`=`GAME_TICKS`.
- PLAY:
  - Outputs: `game_timeout`=0, tg=00.
  - Each `tick` decrements `ticks_left`.
  - A `tick` with `ticks_left`==1 → LATCH, `ticks_left`=0.
  - `start` and `skip` are ignored.
- LATCH: one cycle; `game_timeout`=1, tg=00. Sample `current_score` as S, then:
  - S > pb[p] → pb[p]=S.
  - S > highest → highest=S and `player_won`=p+1.
  - Ties keep the incumbent record and holder.
  - Next state is SHOW_PB.
- Result screens: SHOW_PB (tg1=0, tg2=1), SHOW_HS (tg=10), SHOW_WON (tg=11).
  - Each screen holds for `DWELL_TICKS` ticks, counted by the dwell counter, which clears on screen entry.
  - `skip` advances immediately.
  - Order: SHOW_PB → SHOW_HS → SHOW_WON → IDLE.
- `personal_best` always shows pb of the latched player index.
- Records are plain 7-bit registers. No arithmetic beyond compares and the decrement, so no overflow cases.
- Reset values:
  - State IDLE.
  - `game_timeout`=1; `tg1`=`tg2`=0; `busy`=0.
  - `highest_score`, `personal_best`, `player_won`, `ticks_left`, all pb[] and the latched player all 0.

## Timing
- All outputs are registered.
- `start` seen at edge N → state PLAY, `game_timeout`=0 and `ticks_left`=`GAME_TICKS` valid after edge N.
- Final tick seen at edge M → LATCH after edge M (`game_timeout`=1). Records update at edge M+1; SHOW_PB is also entered at edge M+1.
- `current_score` is sampled in LATCH. The score updater freezes its `Current_Score` once `game_timeout` is high, so the sample is stable.
- Simultaneous events:
  - `start`+`tick` in IDLE: start wins; the tick is not counted.
  - `skip`+`tick` in a SHOW state: advance once.
  - `skip` on the last dwell tick: advance once, not twice.
- Reset mid-game: all records and state are cleared on the next edge. Reset takes priority over every input.
- `tick` is level-sampled. A `tick` held high counts once per cycle, by design.

## Structure
- Shared package `prime_pkg`:
  - State enum `game_state_t`.
  - Display-select constants `DISP_SCORE`=00, `DISP_PB`=01, `DISP_HS`=10, `DISP_WON`=11 (bit1=`tg1`, bit0=`tg2`).
  - `SCORE_W`=7.
- Sub-module `record_keeper`: the pb array, highest score and holder, plus the compare/update logic, enabled by the LATCH strobe. The FSM and both counters stay in `game_sequencer`.

## Test plan
- Reset, then idle 10 cycles → `game_timeout`=1, tg=00, all records 0, `busy`=0.
- Round, player 2, `GAME_TICKS`=3:
  - `start` → `ticks_left` 3,2,1,0 on successive ticks.
  - `game_timeout` falls the cycle after `start` and rises after the third tick.
  - With `current_score`=12 → pb[2]=12, `highest_score`=12, `player_won`=3.
- Round, player 0, score 12 → pb[0]=12; `highest_score` stays 12; `player_won` stays 3 (tie).
- Result sequence, `DWELL_TICKS`=3: tg goes 01 → 10 → 11 → IDLE (00), 3 ticks each.
  - A `skip` in SHOW_HS moves to SHOW_WON on the next cycle.
- Reset pulsed mid-PLAY with `ticks_left`=5 → IDLE, `ticks_left`=0, records cleared. A `start` in the same cycle as reset is ignored.
- `player_sel`=6 with `NUM_PLAYERS`=4 → player 0 latched; `start` pulsed during PLAY → no restart, `ticks_left` unchanged.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and constants for the Prime-Prediction game sequencer.
package prime_pkg;

  localparam int SCORE_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_LATCH    = 3'd2,
    ST_SHOW_PB  = 3'd3,
    ST_SHOW_HS  = 3'd4,
    ST_SHOW_WON = 3'd5
  } game_state_t;

  // Display select: bit1 drives tg1, bit0 drives tg2.
  localparam logic [1:0] DISP_SCORE = 2'b00;
  localparam logic [1:0] DISP_PB    = 2'b01;
  localparam logic [1:0] DISP_HS    = 2'b10;
  localparam logic [1:0] DISP_WON   = 2'b11;

  function automatic logic [1:0] disp_sel(input game_state_t st);
    logic [1:0] sel;
    case (st)
      ST_SHOW_PB:  sel = DISP_PB;
      ST_SHOW_HS:  sel = DISP_HS;
      ST_SHOW_WON: sel = DISP_WON;
      default:     sel = DISP_SCORE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/record_keeper.sv
// Per-player personal bests, overall high score and its holder; updated on the latch strobe.
module record_keeper
  import prime_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               latch_en,
  input  logic [2:0]         latch_player,
  input  logic [2:0]         view_player,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] highest_score,
  output logic [SCORE_W-1:0] personal_best,
  output logic [2:0]         player_won
);

  logic [SCORE_W-1:0] pb_r [8];
  logic [SCORE_W-1:0] pb_s [8];
  logic [SCORE_W-1:0] highest_r;
  logic [SCORE_W-1:0] highest_s;
  logic [SCORE_W-1:0] personal_best_r;
  logic [2:0]         player_won_r;
  logic [2:0]         player_won_s;

  // Record update: strictly greater wins, ties keep the incumbent.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pb_s[i] = pb_r[i];
    end
    highest_s    = highest_r;
    player_won_s = player_won_r;
    if (latch_en) begin
      if (score > pb_r[latch_player]) begin
        pb_s[latch_player] = score;
      end else begin
        pb_s[latch_player] = pb_r[latch_player];
      end
      if (score > highest_r) begin
        highest_s    = score;
        player_won_s = latch_player + 3'd1;
      end else begin
        highest_s    = highest_r;
        player_won_s = player_won_r;
      end
    end else begin
      highest_s    = highest_r;
      player_won_s = player_won_r;
    end
  end

  // Record registers; personal_best follows the player being latched this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        pb_r[i] <= {SCORE_W{1'b0}};
      end
      highest_r       <= {SCORE_W{1'b0}};
      player_won_r    <= 3'd0;
      personal_best_r <= {SCORE_W{1'b0}};
    end else begin
      for (int i = 0; i < 8; i++) begin
        pb_r[i] <= pb_s[i];
      end
      highest_r       <= highest_s;
      player_won_r    <= player_won_s;
      personal_best_r <= pb_s[view_player];
    end
  end

  assign highest_score = highest_r;
  assign personal_best = personal_best_r;
  assign player_won    = player_won_r;

endmodule

// File: rtl/game_sequencer.sv
// Runs one timed round, latches the score into the records and steps through the result screens.
module game_sequencer
  import prime_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int GAME_TICKS  = 30,
  parameter int DWELL_TICKS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               skip,
  input  logic [2:0]         player_sel,
  input  logic [SCORE_W-1:0] current_score,
  output logic               game_timeout,
  output logic               tg1,
  output logic               tg2,
  output logic [SCORE_W-1:0] highest_score,
  output logic [SCORE_W-1:0] personal_best,
  output logic [2:0]         player_won,
  output logic [SCORE_W-1:0] ticks_left,
  output logic               busy
);

  localparam int                 DWELL_W      = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST   = DWELL_W'(DWELL_TICKS - 1);
  localparam logic [SCORE_W-1:0] GAME_LOAD    = SCORE_W'(GAME_TICKS);
  localparam logic [2:0]         PLAYER_LIMIT = 3'(NUM_PLAYERS);

  game_state_t        state_r, state_s;
  logic [SCORE_W-1:0] ticks_left_r, ticks_left_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s, dwell_adv_s;
  logic [2:0]         player_r, player_s;
  logic               latch_en_s;
  logic               screen_done_s;
  logic               game_timeout_r;
  logic               tg1_r, tg2_r;
  logic               busy_r;
  logic [1:0]         disp_s;

  // A skip on the final dwell tick still advances only once.
  assign screen_done_s = skip || (tick && (dwell_r == DWELL_LAST));
  assign disp_s        = disp_sel(state_s);

  // Dwell counter step shared by the result screens.
  always_comb begin
    dwell_adv_s = dwell_r;
    if (screen_done_s) begin
      dwell_adv_s = {DWELL_W{1'b0}};
    end else if (tick) begin
      dwell_adv_s = dwell_r + {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      dwell_adv_s = dwell_r;
    end
  end

  // Next-state, tick countdown, player latch and record strobe.
  always_comb begin
    state_s      = state_r;
    ticks_left_s = ticks_left_r;
    dwell_s      = dwell_r;
    player_s     = player_r;
    latch_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s      = ST_PLAY;
          ticks_left_s = GAME_LOAD;
          if (player_sel >= PLAYER_LIMIT) begin
            player_s = 3'd0;
          end else begin
            player_s = player_sel;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (ticks_left_r == {{(SCORE_W-1){1'b0}}, 1'b1}) begin
            state_s      = ST_LATCH;
            ticks_left_s = {SCORE_W{1'b0}};
          end else begin
            ticks_left_s = ticks_left_r - {{(SCORE_W-1){1'b0}}, 1'b1};
          end
        end else begin
          ticks_left_s = ticks_left_r;
        end
      end
      ST_LATCH: begin
        latch_en_s = 1'b1;
        state_s    = ST_SHOW_PB;
        dwell_s    = {DWELL_W{1'b0}};
      end
      ST_SHOW_PB: begin
        dwell_s = dwell_adv_s;
        if (screen_done_s) begin
          state_s = ST_SHOW_HS;
        end else begin
          state_s = ST_SHOW_PB;
        end
      end
      ST_SHOW_HS: begin
        dwell_s = dwell_adv_s;
        if (screen_done_s) begin
          state_s = ST_SHOW_WON;
        end else begin
          state_s = ST_SHOW_HS;
        end
      end
      ST_SHOW_WON: begin
        dwell_s = dwell_adv_s;
        if (screen_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SHOW_WON;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and counters, with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      ticks_left_r   <= {SCORE_W{1'b0}};
      dwell_r        <= {DWELL_W{1'b0}};
      player_r       <= 3'd0;
      game_timeout_r <= 1'b1;
      tg1_r          <= 1'b0;
      tg2_r          <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      ticks_left_r   <= ticks_left_s;
      dwell_r        <= dwell_s;
      player_r       <= player_s;
      game_timeout_r <= (state_s != ST_PLAY);
      tg1_r          <= disp_s[1];
      tg2_r          <= disp_s[0];
      busy_r         <= (state_s != ST_IDLE);
    end
  end

  record_keeper u_record_keeper (
    .clk           (clk),
    .reset         (reset),
    .latch_en      (latch_en_s),
    .latch_player  (player_r),
    .view_player   (player_s),
    .score         (current_score),
    .highest_score (highest_score),
    .personal_best (personal_best),
    .player_won    (player_won)
  );

  assign game_timeout = game_timeout_r;
  assign tg1          = tg1_r;
  assign tg2          = tg2_r;
  assign ticks_left   = ticks_left_r;
  assign busy         = busy_r;

endmodule
